midi_bus_arbiter: RTL and testbench

MIDI_BUS_ARBITER -- requirements
Module: midi_bus_arbiter

---
 rtl/midi_bus_arbiter_if.sv | 29 ++
 rtl/midi_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_midi_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/midi_bus_arbiter_if.sv
// Bus bundle between the MIDI source channels, the arbiter and the downstream FIFO.
// master : arbiter side (drives strobes, address and FIFO write side)
// slave  : environment side (channels' irq/enable/data and FIFO full flag)
interface midi_bus_arbiter_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();
  logic [N_CH-1:0]   irq;
  logic [N_CH-1:0]   ch_en;
  logic [ADDR_W-1:0] addr;
  logic [N_CH-1:0]   bus_rd;
  logic [DATA_W-1:0] data;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_data;
  logic [ADDR_W-1:0] fifo_chan;
  logic              fifo_wr;
  logic              busy;

  modport master (
    input  irq, ch_en, data, fifo_full,
    output addr, bus_rd, fifo_data, fifo_chan, fifo_wr, busy
  );

  modport slave (
    output irq, ch_en, data, fifo_full,
    input  addr, bus_rd, fifo_data, fifo_chan, fifo_wr, busy
  );
endinterface

// File: rtl/midi_bus_arbiter.sv
// Round-robin arbiter that reads one byte at a time from N_CH MIDI source
// channels over a shared read bus and pushes it, tagged with its channel,
// into a downstream FIFO. Each transfer is IDLE -> READ -> WRITE.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : irq/ch_en/data/fifo_full in; addr/bus_rd/fifo_data/fifo_chan/
//           fifo_wr/busy out (fifo_wr and busy are decoded from state)
module midi_bus_arbiter #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  midi_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [N_CH-1:0]   r_bus_rd;
  logic [DATA_W-1:0] r_fifo_data;
  logic [ADDR_W-1:0] r_fifo_chan;

  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_rot;
  logic              w_found;
  logic [ADDR_W-1:0] w_grant;
  logic              w_load_grant;
  logic              w_capture;
  logic              w_done;

  assign w_req = bus.irq & bus.ch_en;

  // First requesting channel at or above ptr, wrapping modulo N_CH.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_rot   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_rot = w_req >> ((32'(r_ptr) + k) % N_CH);
      if (!w_found && w_rot[0]) begin
        w_found = 1'b1;
        w_grant = ADDR_W'((32'(r_ptr) + k) % N_CH);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_grant = 1'b0;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load_grant = 1'b1;
          w_state_nxt  = S_READ;
        end
      end
      S_READ: begin
        w_capture   = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        // A full FIFO simply holds us here with the byte intact.
        if (!bus.fifo_full) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant, capture and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_addr      <= '0;
      r_bus_rd    <= '0;
      r_fifo_data <= '0;
      r_fifo_chan <= '0;
    end else begin
      if (w_load_grant) begin
        r_addr      <= w_grant;
        r_bus_rd    <= N_CH'(1) << w_grant;
        r_fifo_chan <= w_grant;
      end
      if (w_capture) begin
        r_fifo_data <= bus.data;
        r_bus_rd    <= '0;
      end
      if (w_done) begin
        r_ptr <= ADDR_W'((32'(r_addr) + 32'd1) % N_CH);
      end
    end
  end

  assign bus.addr      = r_addr;
  assign bus.bus_rd    = r_bus_rd;
  assign bus.fifo_data = r_fifo_data;
  assign bus.fifo_chan = r_fifo_chan;
  assign bus.fifo_wr   = w_done;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_midi_bus_arbiter.sv
// Self-checking bench for midi_bus_arbiter: directed scenarios followed by
// randomized transfers, all checked against a transaction-level round-robin model.
module tb_midi_bus_arbiter;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr    = 0;

  always #5 clk = ~clk;

  midi_bus_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  midi_bus_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: first requesting channel at or above the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] req, input int p);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = (p + k) % 4;
      if (((req >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.addr),      32'd0);
    chk({tag, "_busrd"}, 32'(bus.bus_rd),    32'd0);
    chk({tag, "_fdata"}, 32'(bus.fifo_data), 32'd0);
    chk({tag, "_fchan"}, 32'(bus.fifo_chan), 32'd0);
    chk({tag, "_fwr"},   32'(bus.fifo_wr),   32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  // One full transfer starting from IDLE; returns in IDLE at +1 after the edge.
  task automatic xfer(input logic [3:0] irqv, input logic [3:0] env, input logic [7:0] d,
                      input int stall, input bit drop);
    int exp_ch;
    exp_ch = rr_pick(irqv & env, m_ptr);
    bus.irq = irqv; bus.ch_en = env; bus.fifo_full = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    step();
    chk("rd_strobe", 32'(bus.bus_rd), 32'(1) << exp_ch);
    chk("rd_addr",   32'(bus.addr),   32'(exp_ch));
    chk("rd_fwr",    32'(bus.fifo_wr), 32'd0);
    chk("rd_busy",   32'(bus.busy),   32'd1);
    bus.data = d;
    bus.fifo_full = (stall > 0);
    if (drop) begin
      bus.irq = '0;
      bus.ch_en = '0;
    end
    step();
    bus.data = ~d;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_fwr",   32'(bus.fifo_wr),   32'd0);
      chk("stall_busy",  32'(bus.busy),      32'd1);
      chk("stall_fdata", 32'(bus.fifo_data), 32'(d));
      chk("stall_busrd", 32'(bus.bus_rd),    32'd0);
      step();
    end
    bus.fifo_full = 1'b0;
    #1;
    chk("wr_fwr",   32'(bus.fifo_wr),   32'd1);
    chk("wr_fdata", 32'(bus.fifo_data), 32'(d));
    chk("wr_fchan", 32'(bus.fifo_chan), 32'(exp_ch));
    chk("wr_busrd", 32'(bus.bus_rd),    32'd0);
    step();
    chk("post_fwr",  32'(bus.fifo_wr), 32'd0);
    chk("post_busy", 32'(bus.busy),    32'd0);
    m_ptr = (exp_ch + 1) % 4;
  endtask

  initial begin
    logic [3:0] irqv;
    logic [3:0] env;
    reset = 1'b0;
    bus.irq = '0; bus.ch_en = '0; bus.data = '0; bus.fifo_full = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Fairness with everything requesting: 0,1,2,3,0 at one byte per 3 cycles.
    for (int i = 0; i < 5; i++) begin
      chk("fair_model", 32'(rr_pick(4'hF, m_ptr)), 32'(i % 4));
      xfer(4'hF, 4'hF, 8'(8'h10 + i), 0, 1'b0);
    end

    // Single request on channel 2 with 8'h90.
    xfer(4'b0100, 4'hF, 8'h90, 0, 1'b0);
    bus.irq = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold_busy",  32'(bus.busy),   32'd0);
      chk("idle_hold_busrd", 32'(bus.bus_rd), 32'd0);
      chk("idle_hold_addr",  32'(bus.addr),   32'd2);
    end

    // Backpressure: 5 stalled cycles in WRITE.
    xfer(4'b0001, 4'hF, 8'hA5, 5, 1'b0);

    // Mask: channel 0 requests but is disabled.
    xfer(4'b0011, 4'b0010, 8'h21, 0, 1'b0);
    xfer(4'b0011, 4'b0010, 8'h22, 0, 1'b0);

    // Irq and enable drop during READ on channel 3.
    xfer(4'b1000, 4'hF, 8'h3C, 0, 1'b1);

    // Reset during READ of channel 3 with ptr parked at 3.
    xfer(4'b0100, 4'hF, 8'h44, 0, 1'b0);
    bus.irq = 4'b1000; bus.ch_en = 4'hF;
    step();
    chk("rst_pre_busrd", 32'(bus.bus_rd), 32'h8);
    reset = 1'b0;
    bus.irq = '0;
    #1;
    chk_all_zero("rst_mid");
    step();
    chk_all_zero("rst_hold");
    reset = 1'b1;
    step();
    chk("rst_after_fwr",  32'(bus.fifo_wr), 32'd0);
    chk("rst_after_busy", 32'(bus.busy),    32'd0);
    m_ptr = 0;
    xfer(4'b1010, 4'hF, 8'h77, 0, 1'b0);

    // Randomized transfers with random masks, stalls and drops.
    for (int n = 0; n < 40; n++) begin
      irqv = 4'($urandom_range(1, 15));
      env  = 4'($urandom_range(0, 15));
      if ((irqv & env) == 4'd0) env = 4'hF;
      if ($urandom_range(0, 3) == 0) begin
        bus.irq = '0;
        step();
        chk("rnd_idle_busy", 32'(bus.busy), 32'd0);
      end
      xfer(irqv, env, 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
